// File: rtl/uart_pkg.sv
// uart_pkg: shared types for the UART transceiver.
//   parity_t        - frame parity mode (NONE=0, EVEN=1, ODD=2)
//   tx_state_t      - transmit FSM states
//   rx_state_t      - receive FSM states
//   uart_rx_entry_t - one RX FIFO entry {frame_err, parity_err, data}
//   parity_bit()    - parity bit that goes on the line for a payload
package uart_pkg;

    localparam int MAX_DATA_BITS = 8;

    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_EVEN = 2'd1,
        PARITY_ODD  = 2'd2
    } parity_t;

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
    } rx_state_t;

    // Payload is stored at full width; narrower frames are zero-extended.
    typedef struct packed {
        logic                     frame_err;
        logic                     parity_err;
        logic [MAX_DATA_BITS-1:0] data;
    } uart_rx_entry_t;

    // Zero-extension does not change the XOR, so callers may pass narrow payloads widened.
    function automatic logic parity_bit(parity_t mode, logic [MAX_DATA_BITS-1:0] d);
        return (mode == PARITY_ODD) ? ~(^d) : (^d);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through FIFO for received UART entries.
//   clock, reset          - clock, synchronous active-high reset
//   push, push_data       - write request from the RX FSM
//   overrun               - high while a push is refused (full, no pop)
//   head_valid, head_data - current head entry
//   pop_ready             - consumer takes the head when head_valid
module uart_rx_fifo #(
    parameter int  RX_DEPTH = 4,
    parameter type entry_t  = logic [7:0]
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   push,
    input  entry_t push_data,
    output logic   overrun,
    output logic   head_valid,
    input  logic   pop_ready,
    output entry_t head_data
);

    localparam int AW = $clog2(RX_DEPTH);

    entry_t         mem [RX_DEPTH];
    logic [AW:0]    wr_ptr, rd_ptr;
    logic           full, empty, do_push, do_pop;

    // Extra MSB is a wrap bit: same index with differing wrap means full.
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign do_pop     = !empty && pop_ready;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign do_push    = push && (!full || do_pop);
    assign overrun    = push && !do_push;
    assign head_valid = !empty;
    assign head_data  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_transceiver.sv
// uart_transceiver: UART TX serialiser + RX deserialiser with RX FIFO.
//   clock, reset                 - clock, synchronous active-high reset
//   io_tx_valid/ready/bits       - TX byte handshake (ready only when idle)
//   io_rx_valid/ready/bits       - RX FIFO head, popped on valid && ready
//   io_rx_parity_err/frame_err   - error flags of the head entry
//   io_rx_overrun                - pulse when a received byte is dropped
//   io_txd / io_rxd              - serial line out (idle high) / in (async)
module uart_transceiver
    import uart_pkg::*;
#(
    parameter int      DIV       = 868,
    parameter int      DATA_BITS = 8,
    parameter parity_t PARITY    = PARITY_NONE,
    parameter int      STOP_BITS = 1,
    parameter int      RX_DEPTH  = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 io_tx_valid,
    output logic                 io_tx_ready,
    input  logic [DATA_BITS-1:0] io_tx_bits,
    output logic                 io_rx_valid,
    input  logic                 io_rx_ready,
    output logic [DATA_BITS-1:0] io_rx_bits,
    output logic                 io_rx_parity_err,
    output logic                 io_rx_frame_err,
    output logic                 io_rx_overrun,
    output logic                 io_txd,
    input  logic                 io_rxd
);

    localparam int             CW         = $clog2(DIV);
    localparam logic [CW-1:0]  BIT_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0]  HALF_LAST  = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0]  CNT_ONE    = CW'(1);
    localparam logic [3:0]     DATA_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0]     STOP_LAST  = 4'(STOP_BITS - 1);
    localparam bit             HAS_PARITY = (PARITY != PARITY_NONE);

    // ---------------- TX ----------------
    tx_state_t            tx_state, tx_state_next;
    logic [CW-1:0]        tx_cnt;
    logic [3:0]           tx_idx;
    logic [DATA_BITS-1:0] tx_shreg;
    logic                 tx_par, tx_tick, tx_accept;

    assign tx_tick   = (tx_cnt == '0);
    assign tx_accept = io_tx_valid && (tx_state == TX_IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shreg <= '0;
            tx_par   <= 1'b0;
        end else begin
            tx_state <= tx_state_next;
            if (tx_accept) begin
                tx_cnt   <= BIT_LAST;
                tx_idx   <= '0;
                tx_shreg <= io_tx_bits;
                tx_par   <= parity_bit(PARITY, MAX_DATA_BITS'(io_tx_bits));
            end else if (tx_state != TX_IDLE) begin
                tx_cnt <= tx_tick ? BIT_LAST : tx_cnt - CNT_ONE;
                if (tx_tick) begin
                    if (tx_state == TX_DATA) tx_shreg <= tx_shreg >> 1;
                    // tx_idx counts data bits, then stop bits; cleared on each phase change.
                    tx_idx <= (tx_state_next != tx_state) ? 4'd0 : tx_idx + 4'd1;
                end
            end
        end
    end

    always_comb begin
        tx_state_next = tx_state;
        case (tx_state)
            TX_IDLE:   if (io_tx_valid) tx_state_next = TX_START;
            TX_START:  if (tx_tick) tx_state_next = TX_DATA;
            TX_DATA:   if (tx_tick && tx_idx == DATA_LAST)
                           tx_state_next = HAS_PARITY ? TX_PARITY : TX_STOP;
            TX_PARITY: if (tx_tick) tx_state_next = TX_STOP;
            TX_STOP:   if (tx_tick && tx_idx == STOP_LAST) tx_state_next = TX_IDLE;
            default:   tx_state_next = TX_IDLE;
        endcase
    end

    always_comb begin
        io_txd      = 1'b1;
        io_tx_ready = 1'b0;
        case (tx_state)
            TX_IDLE:   io_tx_ready = 1'b1;
            TX_START:  io_txd      = 1'b0;
            TX_DATA:   io_txd      = tx_shreg[0];
            TX_PARITY: io_txd      = tx_par;
            default:   ;
        endcase
    end

    // ---------------- RX ----------------
    logic                 rxd_meta, rxd_sync;
    rx_state_t            rx_state, rx_state_next;
    logic [CW-1:0]        rx_cnt;
    logic [3:0]           rx_idx;
    logic [DATA_BITS-1:0] rx_shreg;
    logic                 rx_pbit, rx_tick;
    logic                 rx_shift, rx_par_cap, rx_done;
    logic                 push_vld;
    uart_rx_entry_t       push_entry, head;

    assign rx_tick = (rx_cnt == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            rxd_meta   <= 1'b1;
            rxd_sync   <= 1'b1;
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_idx     <= '0;
            rx_shreg   <= '0;
            rx_pbit    <= 1'b0;
            push_vld   <= 1'b0;
            push_entry <= '0;
        end else begin
            rxd_meta <= io_rxd;
            rxd_sync <= rxd_meta;
            rx_state <= rx_state_next;
            push_vld <= rx_done;
            if (rx_state == RX_IDLE) begin
                // First sample lands mid start bit, half a period after the edge.
                rx_cnt <= HALF_LAST;
                rx_idx <= '0;
            end else begin
                rx_cnt <= rx_tick ? BIT_LAST : rx_cnt - CNT_ONE;
            end
            if (rx_shift) begin
                rx_shreg <= {rxd_sync, rx_shreg[DATA_BITS-1:1]};
                rx_idx   <= rx_idx + 4'd1;
            end
            if (rx_par_cap) rx_pbit <= rxd_sync;
            if (rx_done) begin
                push_entry.frame_err  <= ~rxd_sync;
                push_entry.parity_err <= HAS_PARITY &&
                    (parity_bit(PARITY, MAX_DATA_BITS'(rx_shreg)) != rx_pbit);
                push_entry.data       <= MAX_DATA_BITS'(rx_shreg);
            end
        end
    end

    always_comb begin
        rx_state_next = rx_state;
        case (rx_state)
            RX_IDLE:   if (!rxd_sync) rx_state_next = RX_START;
            RX_START:  if (rx_tick) rx_state_next = rxd_sync ? RX_IDLE : RX_DATA;
            RX_DATA:   if (rx_tick && rx_idx == DATA_LAST)
                           rx_state_next = HAS_PARITY ? RX_PARITY : RX_STOP;
            RX_PARITY: if (rx_tick) rx_state_next = RX_STOP;
            // Only the first stop bit is checked; back to IDLE right after it.
            RX_STOP:   if (rx_tick) rx_state_next = RX_IDLE;
            default:   rx_state_next = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_shift   = 1'b0;
        rx_par_cap = 1'b0;
        rx_done    = 1'b0;
        if (rx_tick) begin
            case (rx_state)
                RX_DATA:   rx_shift   = 1'b1;
                RX_PARITY: rx_par_cap = 1'b1;
                RX_STOP:   rx_done    = 1'b1;
                default:   ;
            endcase
        end
    end

    uart_rx_fifo #(
        .RX_DEPTH (RX_DEPTH),
        .entry_t  (uart_rx_entry_t)
    ) u_rx_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (push_vld),
        .push_data  (push_entry),
        .overrun    (io_rx_overrun),
        .head_valid (io_rx_valid),
        .pop_ready  (io_rx_ready),
        .head_data  (head)
    );

    assign io_rx_bits       = head.data[DATA_BITS-1:0];
    assign io_rx_parity_err = head.parity_err;
    assign io_rx_frame_err  = head.frame_err;

endmodule

// File: tb/tb_uart_transceiver.sv
// tb_uart_transceiver: directed bench for uart_transceiver at DIV=4.
//   dut_a: 8O1, RX_DEPTH=4 - loopback, parity/frame errors, glitch, overrun, reset
//   dut_b: 8N1             - TX waveform of 0x55
//   dut_c: 7E2             - TX waveform of 0x03
// The RX model is a queue of expected {frame_err, parity_err, data} entries
// with a 4-deep capacity rule; one compare process checks every pop.
module tb_uart_transceiver;
    import uart_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset;
    int   errors = 0;
    int   checks = 0;

    // ---------------- dut_a ----------------
    logic       a_tx_valid, a_tx_ready, a_rx_valid, a_rx_ready;
    logic       a_pe, a_fe, a_ovr, a_txd, a_rxd, line, loop_en;
    logic [7:0] a_tx_bits, a_rx_bits;
    assign a_rxd = loop_en ? a_txd : line;

    uart_transceiver #(.DIV(4), .DATA_BITS(8), .PARITY(PARITY_ODD), .STOP_BITS(1), .RX_DEPTH(4)) dut_a (
        .clock(clock), .reset(reset),
        .io_tx_valid(a_tx_valid), .io_tx_ready(a_tx_ready), .io_tx_bits(a_tx_bits),
        .io_rx_valid(a_rx_valid), .io_rx_ready(a_rx_ready), .io_rx_bits(a_rx_bits),
        .io_rx_parity_err(a_pe), .io_rx_frame_err(a_fe), .io_rx_overrun(a_ovr),
        .io_txd(a_txd), .io_rxd(a_rxd));

    // ---------------- dut_b / dut_c (TX only) ----------------
    logic       b_tx_valid, b_tx_ready, b_txd, b_rx_valid, b_pe, b_fe, b_ovr;
    logic [7:0] b_tx_bits, b_rx_bits;
    logic       c_tx_valid, c_tx_ready, c_txd, c_rx_valid, c_pe, c_fe, c_ovr;
    logic [6:0] c_tx_bits, c_rx_bits;

    uart_transceiver #(.DIV(4), .DATA_BITS(8), .PARITY(PARITY_NONE), .STOP_BITS(1), .RX_DEPTH(4)) dut_b (
        .clock(clock), .reset(reset),
        .io_tx_valid(b_tx_valid), .io_tx_ready(b_tx_ready), .io_tx_bits(b_tx_bits),
        .io_rx_valid(b_rx_valid), .io_rx_ready(1'b0), .io_rx_bits(b_rx_bits),
        .io_rx_parity_err(b_pe), .io_rx_frame_err(b_fe), .io_rx_overrun(b_ovr),
        .io_txd(b_txd), .io_rxd(1'b1));

    uart_transceiver #(.DIV(4), .DATA_BITS(7), .PARITY(PARITY_EVEN), .STOP_BITS(2), .RX_DEPTH(4)) dut_c (
        .clock(clock), .reset(reset),
        .io_tx_valid(c_tx_valid), .io_tx_ready(c_tx_ready), .io_tx_bits(c_tx_bits),
        .io_rx_valid(c_rx_valid), .io_rx_ready(1'b0), .io_rx_bits(c_rx_bits),
        .io_rx_parity_err(c_pe), .io_rx_frame_err(c_fe), .io_rx_overrun(c_ovr),
        .io_txd(c_txd), .io_rxd(1'b1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- RX model ----------------
    logic [9:0] exp_q[$];   // expected entries, oldest first
    logic [9:0] popped[$];  // entries actually popped, for literal checks
    int         exp_ovr = 0;
    int         got_ovr = 0;

    function automatic void model_push(input logic [9:0] e, input bit pop_same);
        if (exp_q.size() >= 4 && !pop_same) exp_ovr++;
        else exp_q.push_back(e);
    endfunction

    always @(negedge clock) begin
        if (!reset) begin
            if (a_ovr) got_ovr++;
            if (a_rx_valid && a_rx_ready) begin
                if (exp_q.size() == 0) chk("rx_unexpected_pop", 0, 1);
                else chk("rx_entry", {a_fe, a_pe, a_rx_bits}, exp_q.pop_front());
                popped.push_back({a_fe, a_pe, a_rx_bits});
            end
        end
    end

    // Drive one 8O1 frame on the line; call at posedge+1. Each bit lasts 4 cycles.
    task automatic line_frame(input logic [7:0] d, input bit flip, input logic stop, input bit pop_same);
        logic [10:0] f;
        f = {stop, (~^d) ^ flip, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            line = f[i];
            repeat (4) @(posedge clock);
            #1;
        end
        line = 1'b1;
        model_push({~stop, flip, d}, pop_same);
        // The push lands in the next cycle; pop exactly then.
        if (pop_same) begin
            @(posedge clock); #1 a_rx_ready = 1'b1;
            @(posedge clock); #1 a_rx_ready = 1'b0;
        end
    endtask

    task automatic a_send(input logic [7:0] d);
        int n;
        n = 0;
        a_tx_valid = 1'b1;
        a_tx_bits  = d;
        @(negedge clock);
        while (!a_tx_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (n >= 200) begin
            errors++; checks++;
            $display("FAIL a_send_timeout: got no tx_ready expected tx_ready within 200 cycles");
        end
        @(posedge clock); #1;
        a_tx_valid = 1'b0;
        if (loop_en) exp_q.push_back({2'b00, d});
    endtask

    task automatic tx_frame_chk(input bit sel, input logic [7:0] d, input logic [10:0] bits,
                                input int nbits, input string name);
        if (sel) begin c_tx_valid = 1'b1; c_tx_bits = d[6:0]; end
        else     begin b_tx_valid = 1'b1; b_tx_bits = d; end
        @(posedge clock); #1;
        b_tx_valid = 1'b0;
        c_tx_valid = 1'b0;
        for (int i = 0; i < nbits * 4; i++) begin
            @(negedge clock);
            chk({name, "_txd"},   sel ? c_txd : b_txd, bits[i/4]);
            chk({name, "_ready"}, sel ? c_tx_ready : b_tx_ready, 0);
        end
        @(negedge clock);
        chk({name, "_ready_after"}, sel ? c_tx_ready : b_tx_ready, 1);
        chk({name, "_txd_idle"},    sel ? c_txd : b_txd, 1);
        @(posedge clock); #1;
    endtask

    task automatic expect_popped(input string name, input logic [9:0] lit [], input int n);
        chk({name, "_count"}, popped.size(), n);
        for (int i = 0; i < n && i < popped.size(); i++) chk(name, popped[i], lit[i]);
        popped.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500us");
        $fatal(1);
    end

    initial begin
        logic [9:0] lit [];
        reset = 1'b1; line = 1'b1; loop_en = 1'b0;
        a_tx_valid = 1'b0; a_tx_bits = '0; a_rx_ready = 1'b0;
        b_tx_valid = 1'b0; b_tx_bits = '0; c_tx_valid = 1'b0; c_tx_bits = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_a_txd", a_txd, 1);
        chk("rst_a_tx_ready", a_tx_ready, 1);
        chk("rst_a_rx_valid", a_rx_valid, 0);
        chk("rst_a_overrun", a_ovr, 0);
        chk("rst_b_txd", b_txd, 1);
        chk("rst_c_tx_ready", c_tx_ready, 1);
        @(posedge clock); #1 reset = 1'b0;

        // 8N1 0x55: 0,1,0,1,0,1,0,1,0,1
        tx_frame_chk(1'b0, 8'h55, 11'b01010101010, 10, "tx_8n1_55");
        // 7E2 0x03: 0,1,1,0,0,0,0,0,0(par),1,1
        tx_frame_chk(1'b1, 8'h03, 11'b11000000110, 11, "tx_7e2_03");

        // Loopback, back-to-back bytes
        loop_en = 1'b1; a_rx_ready = 1'b1;
        a_send(8'h00); a_send(8'hFF); a_send(8'hA5);
        repeat (60) @(posedge clock); #1;
        loop_en = 1'b0;
        lit = '{10'h000, 10'h0FF, 10'h0A5};
        expect_popped("loop", lit, 3);

        // Flipped parity on 0xA5 only
        line_frame(8'hA5, 1'b1, 1'b1, 1'b0);
        line_frame(8'h3C, 1'b0, 1'b1, 1'b0);
        repeat (10) @(posedge clock); #1;
        lit = '{10'h1A5, 10'h03C};
        expect_popped("parity", lit, 2);

        // Stop bit low
        line_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (20) @(posedge clock); #1;
        lit = '{10'h23C};
        expect_popped("frame", lit, 1);

        // One-cycle low glitch on idle line
        line = 1'b0; @(posedge clock); #1 line = 1'b1;
        repeat (20) @(posedge clock);
        @(negedge clock);
        chk("glitch_rx_valid", a_rx_valid, 0);
        chk("glitch_pops", popped.size(), 0);
        @(posedge clock); #1;

        // Overrun: 5 frames, no pops
        a_rx_ready = 1'b0;
        for (int i = 0; i < 5; i++) line_frame(8'h11 + 8'(i), 1'b0, 1'b1, 1'b0);
        repeat (10) @(posedge clock);
        @(negedge clock);
        chk("ovr_pulses", got_ovr, 1);
        chk("ovr_rx_valid", a_rx_valid, 1);
        @(posedge clock); #1 a_rx_ready = 1'b1;
        repeat (10) @(posedge clock); #1 a_rx_ready = 1'b0;
        lit = '{10'h011, 10'h012, 10'h013, 10'h014};
        expect_popped("ovr_keep", lit, 4);

        // Same again, popping in the 5th push cycle
        for (int i = 0; i < 4; i++) line_frame(8'h21 + 8'(i), 1'b0, 1'b1, 1'b0);
        line_frame(8'h25, 1'b0, 1'b1, 1'b1);
        repeat (5) @(posedge clock); #1 a_rx_ready = 1'b1;
        repeat (10) @(posedge clock); #1;
        chk("popsame_ovr_pulses", got_ovr, 1);
        lit = '{10'h021, 10'h022, 10'h023, 10'h024, 10'h025};
        expect_popped("popsame", lit, 5);
        chk("model_vs_dut_ovr", got_ovr, exp_ovr);

        // Reset mid-TX-data and mid-RX-data with a byte sitting in the FIFO
        a_rx_ready = 1'b0;
        line_frame(8'h77, 1'b0, 1'b1, 1'b0);
        repeat (4) @(posedge clock); #1;
        chk("pre_rst_rx_valid", a_rx_valid, 1);
        a_send(8'h5A);
        line = 1'b0; repeat (4) @(posedge clock); #1;
        line = 1'b1; repeat (6) @(posedge clock); #1;
        chk("pre_rst_tx_busy", a_tx_ready, 0);
        reset = 1'b1;
        exp_q.delete();
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        chk("mid_rst_txd", a_txd, 1);
        chk("mid_rst_tx_ready", a_tx_ready, 1);
        chk("mid_rst_rx_valid", a_rx_valid, 0);
        @(posedge clock); #1;
        popped.delete();
        a_rx_ready = 1'b1;
        line_frame(8'h96, 1'b0, 1'b1, 1'b0);
        repeat (10) @(posedge clock); #1;
        lit = '{10'h096};
        expect_popped("post_rst", lit, 1);
        chk("model_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_transceiver.md
# uart_transceiver

Synthesizable, parametrised UART transceiver: the clocked successor to the behavioural UART console used on the functional bench. It serialises bytes from a valid/ready TX port and deserialises the line into a small RX FIFO. Data width, parity, stop bits, baud divisor and FIFO depth are configurable, and parity and framing errors are reported per byte. It sits between an MMIO/TileLink UART register front-end and the board pins or the bench line model.

## Interface
- `DIV`, 868: clock cycles per bit (100 MHz / 115200); ≥ 4.
- `DATA_BITS`, 8: payload bits per frame, 5..8.
- `PARITY`, `PARITY_NONE`: `uart_pkg::parity_t`, one of NONE/EVEN/ODD.
- `STOP_BITS`, 1: 1 or 2; TX sends all stop bits, RX checks only the first.
- `RX_DEPTH`, 4: RX FIFO entries, power of two, ≥ 2.

Ports:
- `clock`, input, 1: sole clock.
- `reset`, input, 1: synchronous, active-high.
- `io_tx_valid`, input, 1: TX byte offered.
- `io_tx_ready`, output, 1: TX idle, can accept a byte.
- `io_tx_bits`, input, DATA_BITS: TX payload.
- `io_rx_valid`, output, 1: FIFO head valid.
- `io_rx_ready`, input, 1: consumer pops the head.
- `io_rx_bits`, output, DATA_BITS: head payload.
- `io_rx_parity_err`, output, 1: head byte failed parity (0 if PARITY=NONE).
- `io_rx_frame_err`, output, 1: head byte's first stop bit sampled 0.
- `io_rx_overrun`, output, 1: one-cycle pulse; a received byte was dropped because the FIFO was full.
- `io_txd`, output, 1: serial line out, idle high.
- `io_rxd`, input, 1: serial line in, asynchronous.

## Operation
- Reset values: `io_txd`=1, `io_tx_ready`=1, `io_rx_valid`=0, `io_rx_overrun`=0; both FSMs in IDLE; FIFO empty. A reset mid-frame aborts the frame, and `io_txd` is 1 on the cycle after reset is sampled.
- TX FSM IDLE→START→DATA→PARITY→STOP→IDLE. PARITY is skipped when PARITY=NONE.
  - A byte is accepted on `io_tx_valid && io_tx_ready`.
  - `io_tx_ready` is high only in IDLE.
  - Data is sent LSB first.
  - EVEN: the parity bit is the XOR of the payload. ODD: its inverse.
- RX path: `io_rxd` passes through a 2-flop synchronizer. The FSM runs IDLE→START→DATA→PARITY→STOP→IDLE.
  - IDLE: wait for synchronised `rxd`=0.
  - START: re-sample at DIV/2 cycles. If 1, this is a false start and the FSM returns to IDLE with no push.
  - DATA/PARITY/STOP: sample every DIV cycles at bit centre, LSB first.
  - After the first stop-bit sample, push {frame_err, parity_err, data} and return to IDLE immediately. A second stop bit is not waited for, which allows back-to-back frames.
- FIFO behaviour:
  - First-word-fall-through.
  - Pop on `io_rx_valid && io_rx_ready`.
  - Push while full with no same-cycle pop: drop the new byte, keep contents, pulse `io_rx_overrun`.
  - Push and pop in the same cycle while full: both succeed, no overrun.
  - Empty pop is ignored.
- Pointers are log2(RX_DEPTH)+1 bits with wrap bit. Full means low bits equal and wrap bits differ.

## Timing
- TX: `io_txd` drops to 0 the cycle after the accepting handshake. Each bit is held exactly DIV cycles.
- TX frame length is (1+DATA_BITS+P+STOP_BITS)·DIV cycles, where P=0/1. `io_tx_ready` rises on the cycle after the last stop-bit cycle.
- RX:
  - START mid-sample occurs DIV/2 cycles after the synchronised falling edge, i.e. 2 + DIV/2 cycles after the pin edge.
  - The push happens on the cycle after the stop-bit sample.
  - `io_rx_valid` is high on the cycle after the push.
- Bit-period counter: ⌈log2 DIV⌉ bits, counts DIV-1 down to 0, reloads at 0. Integer DIV/2 rounds down.
- The TX and RX FSMs are fully independent; simultaneous activity is legal.

## Structure
- `uart_pkg` holds:
  - `parity_t` (NONE=0, EVEN=1, ODD=2);
  - `tx_state_t`/`rx_state_t` enums;
  - the `uart_rx_entry_t` packed struct {frame_err, parity_err, data}.
- One sub-module, `uart_rx_fifo`, parametrised by RX_DEPTH and the entry type. The TX and RX FSMs live in the top module.

## Test plan
Bench uses DIV=4 unless stated.
- TX, 8N1, send 0x55 → `io_txd` sequence 0,1,0,1,0,1,0,1,0,1, each held 4 cycles. `io_tx_ready` stays low for 40 cycles after accept.
- TX, DATA_BITS=7, EVEN, STOP_BITS=2, send 0x03 → frame 0,1,1,0,0,0,0,0,0(parity),1,1 = 11 bits, 44 cycles.
- RX loopback (`io_txd`→`io_rxd`), 8O1, bytes 0x00, 0xFF, 0xA5 back-to-back → popped in order with both error flags 0. Inject flipped parity on 0xA5 → `io_rx_parity_err`=1 for that entry only.
- RX, stop bit driven 0 on 0x3C → entry 0x3C with `io_rx_frame_err`=1. A 1-cycle low glitch on idle `io_rxd` → no push.
- RX_DEPTH=4, no pops, receive 5 bytes → first 4 retained, 5th dropped, one `io_rx_overrun` pulse. Repeat with a pop in the push cycle → 5th retained, no overrun.
- Reset asserted mid-TX-data and mid-RX-data → next cycle `io_txd`=1, `io_tx_ready`=1, `io_rx_valid`=0. The next full frame is received correctly.
